// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-flop synchroniser, false-start reject,
// optional parity, 1/2 stop bits, parity/framing flags, break hold-off.
// Ports: clk, rst (sync, active-high), rx_pin (async, idle high),
//   recv_en (1-cycle strobe), recv_data, parity_err, frame_err.
// Optional: define UART_RX_MAJORITY_EN for 3-sample majority voting.
module uart_rx_param #(
    parameter int CLK_FRE   = 50,
    parameter int UART_RATE = 115200,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_pin,
    output logic                 recv_en,
    output logic [DATA_BITS-1:0] recv_data,
    output logic                 parity_err,
    output logic                 frame_err
);

    localparam int RATE_CNT = CLK_FRE * 1000000 / UART_RATE - 1;
    localparam int MID      = RATE_CNT / 2;
    localparam int CW       = $clog2(RATE_CNT + 1) + 1;

    // With voting, the decision lands one clock after the nominal point.
    // Only the start decision needs the shift; later bits inherit it.
`ifdef UART_RX_MAJORITY_EN
    localparam int START_PT = MID + 1;
`else
    localparam int START_PT = MID;
`endif

    localparam logic [CW-1:0] RATE_C  = CW'(RATE_CNT);
    localparam logic [CW-1:0] START_C = CW'(START_PT);
    localparam logic [3:0]    LAST_D  = 4'(DATA_BITS - 1);
    localparam logic [3:0]    LAST_S  = 4'(STOP_BITS - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_PAR   = 3'd3;
    localparam logic [2:0] S_STOP  = 3'd4;
    localparam logic [2:0] S_BRK   = 3'd5;

    logic                 sync1_q, rxs_q;
    logic [2:0]           state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [3:0]           bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 perr_sh_q, perr_sh_d;
    logic                 ferr_sh_q, ferr_sh_d;
    logic                 recv_en_q, recv_en_d;
    logic [DATA_BITS-1:0] recv_data_q, recv_data_d;
    logic                 parity_err_q, parity_err_d;
    logic                 frame_err_q, frame_err_d;
    logic                 samp;
    logic                 stop_bad;
    logic                 par_x;

`ifdef UART_RX_MAJORITY_EN
    // Samples taken one and two clocks before the decision point.
    logic [1:0] hist_q, hist_d;
    assign hist_d = {hist_q[0], rxs_q};
    assign samp   = (hist_q[1] & hist_q[0]) | (hist_q[1] & rxs_q) |
                    (hist_q[0] & rxs_q);
    always_ff @(posedge clk) begin
        if (rst) hist_q <= 2'b11;
        else     hist_q <= hist_d;
    end
`else
    assign samp = rxs_q;
`endif

    assign stop_bad = ferr_sh_q | ~samp;
    assign par_x    = ^{shift_q, samp};

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + 1'b1;
        bit_d        = bit_q;
        shift_d      = shift_q;
        perr_sh_d    = perr_sh_q;
        ferr_sh_d    = ferr_sh_q;
        recv_en_d    = 1'b0;
        recv_data_d  = recv_data_q;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!rxs_q) state_d = S_START;
            end
            S_START: begin
                if (cnt_q == START_C) begin
                    cnt_d     = '0;
                    bit_d     = '0;
                    perr_sh_d = 1'b0;
                    ferr_sh_d = 1'b0;
                    // A high sample means the low pulse was a glitch.
                    state_d   = samp ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (cnt_q == RATE_C) begin
                    cnt_d   = '0;
                    shift_d = {samp, shift_q[DATA_BITS-1:1]};
                    if (bit_q == LAST_D) begin
                        bit_d   = '0;
                        state_d = (PARITY != 0) ? S_PAR : S_STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            S_PAR: begin
                if (cnt_q == RATE_C) begin
                    cnt_d     = '0;
                    bit_d     = '0;
                    state_d   = S_STOP;
                    perr_sh_d = (PARITY == 1) ? ~par_x : par_x;
                end
            end
            S_STOP: begin
                if (cnt_q == RATE_C) begin
                    cnt_d     = '0;
                    ferr_sh_d = stop_bad;
                    if (bit_q == LAST_S) begin
                        // Finish at the centre of the last stop bit so a
                        // back-to-back start edge is not missed.
                        bit_d        = '0;
                        recv_en_d    = 1'b1;
                        recv_data_d  = shift_q;
                        parity_err_d = perr_sh_q;
                        frame_err_d  = stop_bad;
                        state_d      = stop_bad ? S_BRK : S_IDLE;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            S_BRK: begin
                cnt_d = '0;
                if (rxs_q) state_d = S_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q      <= 1'b1;
            rxs_q        <= 1'b1;
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            perr_sh_q    <= 1'b0;
            ferr_sh_q    <= 1'b0;
            recv_en_q    <= 1'b0;
            recv_data_q  <= '0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            sync1_q      <= rx_pin;
            rxs_q        <= sync1_q;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            perr_sh_q    <= perr_sh_d;
            ferr_sh_q    <= ferr_sh_d;
            recv_en_q    <= recv_en_d;
            recv_data_q  <= recv_data_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign recv_en    = recv_en_q;
    assign recv_data  = recv_data_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: 8N1, 8E1 and 8N2 instances
// driven by a bit-level serial sender with hand-computed expectations.
module tb_uart_rx_param;

    localparam int BIT = 434;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx [3];
    logic       en [3];
    logic [7:0] dat [3];
    logic       perr [3];
    logic       ferr [3];

    int cyc = 0;
    int n_str [3];
    int t_last [3];
    int t_prev [3];
    int vec_cnt = 0;
    int err_cnt = 0;

    typedef struct {
        int         dut;
        logic [7:0] data;
        logic       pbit;
        logic       stop_val;
        logic [7:0] exp_data;
        logic       exp_perr;
        logic       exp_ferr;
    } vec_t;

    vec_t tbl [8];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (en[i]) begin
                n_str[i]  = n_str[i] + 1;
                t_prev[i] = t_last[i];
                t_last[i] = cyc;
            end
        end
    end

    uart_rx_param #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
        .clk(clk), .rst(rst), .rx_pin(rx[0]), .recv_en(en[0]),
        .recv_data(dat[0]), .parity_err(perr[0]), .frame_err(ferr[0]));

    uart_rx_param #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u1 (
        .clk(clk), .rst(rst), .rx_pin(rx[1]), .recv_en(en[1]),
        .recv_data(dat[1]), .parity_err(perr[1]), .frame_err(ferr[1]));

    uart_rx_param #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u2 (
        .clk(clk), .rst(rst), .rx_pin(rx[2]), .recv_en(en[2]),
        .recv_data(dat[2]), .parity_err(perr[2]), .frame_err(ferr[2]));

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        vec_cnt++;
        if (act != exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_rng(input string nm, input int act,
                           input int lo, input int hi);
        vec_cnt++;
        if (act < lo || act > hi) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d..%0d", nm, act, lo, hi);
        end
    endtask

    // One frame; optional trailing low hold emulates a line break.
    task automatic send(input int d, input logic [7:0] data,
                        input bit par_en, input logic pbit,
                        input int nstop, input logic stop_val,
                        input int low_hold);
        rx[d] = 1'b0;
        wait_clks(BIT);
        for (int i = 0; i < 8; i++) begin
            rx[d] = data[i];
            wait_clks(BIT);
        end
        if (par_en) begin
            rx[d] = pbit;
            wait_clks(BIT);
        end
        for (int s = 0; s < nstop; s++) begin
            rx[d] = (s == 0) ? stop_val : 1'b1;
            wait_clks(BIT);
        end
        if (low_hold > 0) begin
            rx[d] = 1'b0;
            wait_clks(low_hold);
        end
        rx[d] = 1'b1;
    endtask

    task automatic send_chk(input int d, input logic [7:0] data,
                            input logic pbit, input logic stop_val,
                            input logic [7:0] ed, input logic ep,
                            input logic ef);
        int c0;
        c0 = n_str[d];
        send(d, data, d == 1, pbit, (d == 2) ? 2 : 1, stop_val, 0);
        wait_clks(BIT);
        chk($sformatf("strobes d%0d %02h", d, data), n_str[d], c0 + 1);
        chk($sformatf("data d%0d %02h", d, data), dat[d], ed);
        chk($sformatf("perr d%0d %02h", d, data), perr[d], ep);
        chk($sformatf("ferr d%0d %02h", d, data), ferr[d], ef);
    endtask

    initial begin
        int t0;
        int c0;
        int c1;
        logic [7:0] v;

        for (int i = 0; i < 3; i++) begin
            rx[i]     = 1'b1;
            n_str[i]  = 0;
            t_last[i] = 0;
            t_prev[i] = 0;
        end

        tbl[0] = '{0, 8'h55, 1'b0, 1'b1, 8'h55, 1'b0, 1'b0};
        tbl[1] = '{0, 8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
        tbl[2] = '{1, 8'hA3, 1'b1, 1'b1, 8'hA3, 1'b1, 1'b0};
        tbl[3] = '{1, 8'h01, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0};
        tbl[4] = '{1, 8'hA3, 1'b0, 1'b1, 8'hA3, 1'b0, 1'b0};
        tbl[5] = '{1, 8'h01, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0};
        tbl[6] = '{2, 8'h3C, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b0};
        tbl[7] = '{2, 8'hC3, 1'b0, 1'b0, 8'hC3, 1'b0, 1'b1};

        wait_clks(5);
        chk("reset en", en[0], 0);
        chk("reset data", dat[0], 0);
        chk("reset perr", perr[0], 0);
        chk("reset ferr", ferr[0], 0);
        rst = 1'b0;
        wait_clks(10);

        // Latency of the first 8N1 frame from the start edge.
        t0 = cyc;
        c0 = n_str[0];
        send(0, 8'h55, 1'b0, 1'b0, 1, 1'b1, 0);
        wait_clks(BIT);
        chk("lat strobes", n_str[0], c0 + 1);
        chk_rng("latency", t_last[0] - t0, 4124, 4126);
        chk("lat data", dat[0], 8'h55);

        for (int i = 0; i < 8; i++) begin
            send_chk(tbl[i].dut, tbl[i].data, tbl[i].pbit,
                     tbl[i].stop_val, tbl[i].exp_data,
                     tbl[i].exp_perr, tbl[i].exp_ferr);
        end

        // Framing error followed by a 20-bit break.
        c0 = n_str[0];
        send(0, 8'h3C, 1'b0, 1'b0, 1, 1'b0, 20 * BIT);
        wait_clks(2 * BIT);
        chk("brk strobes", n_str[0], c0 + 1);
        chk("brk data", dat[0], 8'h3C);
        chk("brk ferr", ferr[0], 1);
        send_chk(0, 8'h7E, 1'b0, 1'b1, 8'h7E, 1'b0, 1'b0);

        // Short low glitch on an idle line.
        c0 = n_str[0];
        rx[0] = 1'b0;
        wait_clks(100);
        rx[0] = 1'b1;
        wait_clks(2 * BIT);
        chk("glitch strobes", n_str[0], c0);
        send_chk(0, 8'h81, 1'b0, 1'b1, 8'h81, 1'b0, 1'b0);

        // Back-to-back 8N2 frames with no idle time between them.
        c0 = n_str[2];
        send(2, 8'h00, 1'b0, 1'b0, 2, 1'b1, 0);
        v = dat[2];
        c1 = n_str[2];
        send(2, 8'hFF, 1'b0, 1'b0, 2, 1'b1, 0);
        wait_clks(BIT);
        chk("b2b first data", v, 8'h00);
        chk("b2b first count", c1, c0 + 1);
        chk("b2b strobes", n_str[2], c0 + 2);
        chk("b2b data", dat[2], 8'hFF);
        chk_rng("b2b spacing", t_last[2] - t_prev[2],
                11 * BIT - 1, 11 * BIT + 1);

        // Reset mid-frame (data bit 4 of 0x96).
        c0 = n_str[0];
        v = 8'h96;
        rx[0] = 1'b0;
        wait_clks(BIT);
        for (int i = 0; i < 4; i++) begin
            rx[0] = v[i];
            wait_clks(BIT);
        end
        rx[0] = v[4];
        wait_clks(200);
        rst = 1'b1;
        wait_clks(3);
        chk("rst en", en[0], 0);
        chk("rst data", dat[0], 0);
        chk("rst perr", perr[0], 0);
        chk("rst ferr", ferr[0], 0);
        rx[0] = 1'b1;
        rst = 1'b0;
        wait_clks(2 * BIT);
        chk("rst no strobe", n_str[0], c0);
        send_chk(0, 8'h69, 1'b0, 1'b1, 8'h69, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vec_cnt, err_cnt);
        $finish;
    end

endmodule
